// File: rtl/wave_pwm_dac.sv
// Selects and scales one waveform sample and drives a fixed 256-count PWM frame to a 1-bit RC DAC.
// Optional first-order sigma-delta output sd_out when WAVE_PWM_SD_EN is defined.
module wave_pwm_dac #(
  parameter int unsigned PRESCALE   = 1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] sel,
  input  logic [7:0] saw,
  input  logic [7:0] revsaw,
  input  logic [7:0] triangl,
  input  logic [7:0] meander,
  input  logic [7:0] gain,
  output logic       pwm_out,
  output logic       frame_start,
  output logic       busy,
  output logic [7:0] duty_mon
`ifdef WAVE_PWM_SD_EN
  ,
  output logic       sd_out
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [1:0]  state_reg;
  logic [1:0]  state_next;
  logic [15:0] prescaler_reg;
  logic [7:0]  pwm_cnt_reg;
  logic [7:0]  duty_reg;
  logic        pwm_out_reg;
  logic        frame_start_reg;

  logic [7:0]  sample;
  logic [8:0]  gain_plus;
  logic [16:0] product;
  logic [7:0]  scaled;
  logic        tick;
  logic        wrap;
  logic        latch;

  always_comb begin
    sample = 8'h00;
    case (sel)
      2'd0:    sample = saw;
      2'd1:    sample = revsaw;
      2'd2:    sample = triangl;
      default: sample = meander[0] ? 8'hFF : 8'h00;
    endcase
  end

  // gain 255 maps to a multiplier of 256, so full scale survives the >>8 exactly.
  assign gain_plus = {1'b0, gain} + 9'd1;
  assign product   = {9'd0, sample} * {8'd0, gain_plus};
  assign scaled    = product[15:8];

  logic unused_bits;
  assign unused_bits = ^{meander[7:1], product[16]};

  assign tick = (state_reg != IDLE) && (prescaler_reg == PRE_MAX);
  assign wrap = tick && (pwm_cnt_reg == 8'hFF);

  always_comb begin
    state_next = state_reg;
    latch      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en) begin
          state_next = RUN;
          latch      = 1'b1;
        end
      end
      RUN: begin
        if (wrap) latch = 1'b1;
        if (!en) state_next = STOP;
      end
      STOP: begin
        // A stop always lets the frame finish; the wrap ends the run without a new latch.
        if (wrap)    state_next = IDLE;
        else if (en) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_reg <= 16'd0;
      pwm_cnt_reg   <= 8'd0;
    end else if (state_reg == IDLE) begin
      prescaler_reg <= 16'd0;
      pwm_cnt_reg   <= 8'd0;
    end else if (tick) begin
      prescaler_reg <= 16'd0;
      pwm_cnt_reg   <= pwm_cnt_reg + 8'd1;
    end else begin
      prescaler_reg <= prescaler_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_reg        <= 8'd0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= latch;
      if (latch) duty_reg <= scaled;
    end
  end

  // Duty 255 leaves count 255 low, so 100% high is never produced.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_out_reg <= IDLE_LEVEL;
    end else if (state_reg == IDLE) begin
      pwm_out_reg <= IDLE_LEVEL;
    end else begin
      pwm_out_reg <= (pwm_cnt_reg < duty_reg);
    end
  end

`ifdef WAVE_PWM_SD_EN
  logic [8:0] acc_reg;
  logic [8:0] acc_sum;

  assign acc_sum = {1'b0, acc_reg[7:0]} + {1'b0, duty_reg};

  // acc bit 8 holds the last carry, which is exactly the sigma-delta output bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg <= 9'd0;
    end else if (state_reg == IDLE) begin
      acc_reg <= 9'd0;
    end else if (tick) begin
      acc_reg <= acc_sum;
    end
  end

  assign sd_out = acc_reg[8];
`endif

  assign pwm_out     = pwm_out_reg;
  assign frame_start = frame_start_reg;
  assign busy        = (state_reg != IDLE);
  assign duty_mon    = duty_reg;

endmodule

// File: tb/tb_wave_pwm_dac.sv
// Directed bench for wave_pwm_dac: scoreboard of expected latched duties plus per-frame PWM high counts.
module tb_wave_pwm_dac;

  logic       clk = 1'b0;
  logic       reset, reset4, en, en4;
  logic [1:0] sel;
  logic [7:0] saw, revsaw, triangl, meander, gain;

  logic       pwm_out, frame_start, busy;
  logic [7:0] duty_mon;
  logic       pwm_out4, frame_start4, busy4;
  logic [7:0] duty_mon4;
`ifdef WAVE_PWM_SD_EN
  logic       sd_out, sd_out4;
`endif

  int total = 0;
  int bad   = 0;
  int highs;
  int fs_cnt;
  int toggles;
  logic prev_sd;
  int exp_q[$];

  always #5 clk = ~clk;

  wave_pwm_dac #(.PRESCALE(1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .en(en), .sel(sel), .saw(saw), .revsaw(revsaw),
    .triangl(triangl), .meander(meander), .gain(gain), .pwm_out(pwm_out),
    .frame_start(frame_start), .busy(busy), .duty_mon(duty_mon)
`ifdef WAVE_PWM_SD_EN
    , .sd_out(sd_out)
`endif
  );

  wave_pwm_dac #(.PRESCALE(4), .IDLE_LEVEL(1'b0)) dut4 (
    .clk(clk), .reset(reset4), .en(en4), .sel(sel), .saw(saw), .revsaw(revsaw),
    .triangl(triangl), .meander(meander), .gain(gain), .pwm_out(pwm_out4),
    .frame_start(frame_start4), .busy(busy4), .duty_mon(duty_mon4)
`ifdef WAVE_PWM_SD_EN
    , .sd_out(sd_out4)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag, input logic [7:0] obs);
    int e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=%0d expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, {24'd0, obs}, e);
    end
  endtask

  task automatic clks(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      highs  += int'(pwm_out);
      fs_cnt += int'(frame_start);
    end
  endtask

  initial begin
    reset = 1'b1; reset4 = 1'b1; en = 1'b0; en4 = 1'b0;
    sel = 2'd0; saw = 8'd0; revsaw = 8'd0; triangl = 8'd0; meander = 8'd0; gain = 8'd0;
    repeat (3) step();
    check("rst_pwm", pwm_out, 0);
    check("rst_fs", frame_start, 0);
    check("rst_busy", busy, 0);
    check("rst_duty", duty_mon, 0);
    reset = 1'b0; reset4 = 1'b0;
    step();
    check("idle_busy", busy, 0);

    // saw 0x40 at unity gain
    sel = 2'd0; saw = 8'h40; gain = 8'd255; en = 1'b1;
    exp_q.push_back(64);
    step();
    check("start_fs", frame_start, 1);
    check("start_busy", busy, 1);
    check_pop("start_duty", duty_mon);
    $display("txn start duty=%0d", duty_mon);

    // triangle 200 at gain 127 -> 100
    sel = 2'd2; triangl = 8'd200; gain = 8'd127;
    exp_q.push_back(100);
    highs = 0; fs_cnt = 0;
    clks(255);
    check("f1_no_early_fs", fs_cnt, 0);
    check("f1_duty_hold", duty_mon, 64);
    clks(1);
    check("f1_highs", highs, 64);
    check("f1_fs", frame_start, 1);
    check_pop("f1_duty", duty_mon);
    $display("txn frame highs=%0d next duty=%0d", highs, duty_mon);

    // meander high at unity -> 255
    sel = 2'd3; meander = 8'h01; gain = 8'd255;
    exp_q.push_back(255);
    highs = 0; fs_cnt = 0;
    clks(256);
    check("f2_highs", highs, 100);
    check("f2_fs", frame_start, 1);
    check_pop("f2_duty", duty_mon);
    $display("txn frame highs=%0d next duty=%0d", highs, duty_mon);

    // gain 0 -> duty 0
    gain = 8'd0;
    exp_q.push_back(0);
    highs = 0; fs_cnt = 0;
    clks(256);
    check("f3_highs", highs, 255);
    check("f3_fs", frame_start, 1);
    check_pop("f3_duty", duty_mon);
    $display("txn frame highs=%0d next duty=%0d", highs, duty_mon);

    sel = 2'd0; saw = 8'd16; revsaw = 8'd240; gain = 8'd255;
    exp_q.push_back(16);
    highs = 0; fs_cnt = 0;
    clks(256);
    check("f4_highs_zero", highs, 0);
    check("f4_fs", frame_start, 1);
    check_pop("f4_duty", duty_mon);
    $display("txn frame highs=%0d next duty=%0d", highs, duty_mon);

    // sel change at pwm_cnt=10 takes effect only at the wrap
    highs = 0; fs_cnt = 0;
    clks(10);
    sel = 2'd1;
    exp_q.push_back(240);
    clks(245);
    check("f5_no_early_fs", fs_cnt, 0);
    check("f5_duty_hold", duty_mon, 16);
    clks(1);
    check("f5_highs", highs, 16);
    check("f5_fs", frame_start, 1);
    check_pop("f5_duty", duty_mon);
    $display("txn frame highs=%0d next duty=%0d", highs, duty_mon);

    // soft stop at pwm_cnt=50
    highs = 0; fs_cnt = 0;
    clks(50);
    en = 1'b0;
    clks(205);
    check("stop_busy_hold", busy, 1);
    check("stop_no_fs", fs_cnt, 0);
    clks(1);
    check("stop_wrap_busy", busy, 0);
    check("stop_wrap_fs", frame_start, 0);
    check("stop_highs", highs, 240);
    step();
    check("stop_idle_pwm", pwm_out, 0);
    check("stop_idle_busy", busy, 0);
    check("stop_duty_kept", duty_mon, 240);
    $display("txn stop highs=%0d busy=%0d", highs, busy);

    // separate run: drop en at 60, reassert at 100
    sel = 2'd0; saw = 8'h80; gain = 8'd255; en = 1'b1;
    exp_q.push_back(128);
    step();
    check("run2_fs", frame_start, 1);
    check_pop("run2_duty", duty_mon);
    highs = 0; fs_cnt = 0;
    clks(60);
    en = 1'b0;
    clks(40);
    check("run2_stop_busy", busy, 1);
    en = 1'b1;
    saw = 8'h20;
    exp_q.push_back(32);
    clks(155);
    check("run2_no_early_fs", fs_cnt, 0);
    clks(1);
    check("run2_highs", highs, 128);
    check("run2_wrap_fs", frame_start, 1);
    check("run2_wrap_busy", busy, 1);
    check_pop("run2_wrap_duty", duty_mon);
    $display("txn resume highs=%0d next duty=%0d", highs, duty_mon);
    en = 1'b0;

    // PRESCALE=4 instance: 1024-clk frames, then async reset mid-frame
    sel = 2'd0; saw = 8'h80; gain = 8'd255; en4 = 1'b1;
    exp_q.push_back(128);
    step();
    check("p4_fs", frame_start4, 1);
    check_pop("p4_duty", duty_mon4);
    highs = 0; fs_cnt = 0; toggles = 0;
`ifdef WAVE_PWM_SD_EN
    check("p4_sd_start", sd_out4, 0);
    prev_sd = sd_out4;
`else
    prev_sd = 1'b0;
`endif
    for (int i = 0; i < 1023; i++) begin
      step();
      highs  += int'(pwm_out4);
      fs_cnt += int'(frame_start4);
`ifdef WAVE_PWM_SD_EN
      if (sd_out4 !== prev_sd) toggles++;
      prev_sd = sd_out4;
`endif
    end
    check("p4_no_early_fs", fs_cnt, 0);
    check("p4_highs", highs, 512);
`ifdef WAVE_PWM_SD_EN
    check("p4_sd_toggles", toggles, 254);
`endif
    exp_q.push_back(128);
    step();
    check("p4_frame_fs", frame_start4, 1);
    check_pop("p4_frame_duty", duty_mon4);
    $display("txn p4 frame highs=%0d toggles=%0d", highs, toggles);
    repeat (512) step();
    check("p4_pre_rst_pwm", pwm_out4, 1);
    check("p4_pre_rst_busy", busy4, 1);
    reset4 = 1'b1;
    #1;
    check("p4_rst_pwm", pwm_out4, 0);
    check("p4_rst_busy", busy4, 0);
    check("p4_rst_duty", duty_mon4, 0);
    $display("txn p4 reset pwm=%0d busy=%0d duty=%0d", pwm_out4, busy4, duty_mon4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
